// File: rtl/inlet_dispense_sequencer_if.sv
// Handshake/bus bundle between a run controller and the inlet dispense sequencer.
interface inlet_dispense_sequencer_if #(
  parameter int N_INLETS = 3,
  parameter int CNT_W    = 16
);
  logic                        i_start;
  logic                        i_abort;
  logic [N_INLETS*CNT_W-1:0]   i_dur;
  logic [N_INLETS-1:0]         o_valve_en;
  logic                        o_flush_en;
  logic                        o_busy;
  logic                        o_done;
  logic                        o_aborted;
  logic [2:0]                  o_cur_inlet;

  modport master (
    output i_start, i_abort, i_dur,
    input  o_valve_en, o_flush_en, o_busy, o_done, o_aborted, o_cur_inlet
  );

  modport slave (
    input  i_start, i_abort, i_dur,
    output o_valve_en, o_flush_en, o_busy, o_done, o_aborted, o_cur_inlet
  );
endinterface

// File: rtl/inlet_dispense_sequencer.sv
// Timed inlet valve / outlet flush sequencer: doses each nonzero inlet in index order,
// settles with valves closed after each dose, then flushes and pulses done.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start, all valves closed
// S_OPEN   | valve r_idx open, r_cnt counts remaining dose cycles
// S_SETTLE | valves closed after dosing r_idx, r_cnt counts settle cycles
// S_FLUSH  | outlet flush valve open, r_cnt counts flush cycles
// S_DONE   | one-cycle completion pulse, busy still high
module inlet_dispense_sequencer #(
  parameter int N_INLETS   = 3,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 8,
  parameter int FLUSH_CYC  = 16
) (
  input logic                     clk,
  input logic                     rst,
  inlet_dispense_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_OPEN   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]                r_state;
  logic [2:0]                r_idx;
  logic [CNT_W-1:0]          r_cnt;
  logic [N_INLETS*CNT_W-1:0] r_dur;

  logic                      w_first_vld;
  logic [2:0]                w_first_idx;
  logic [CNT_W-1:0]          w_first_dur;
  logic                      w_next_vld;
  logic [2:0]                w_next_idx;
  logic [CNT_W-1:0]          w_next_dur;
  logic                      w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  // Descending scans leave the lowest qualifying index in the result, so zero-duration
  // inlets are skipped within the same cycle.
  always_comb begin
    w_first_vld = 1'b0;
    w_first_idx = '0;
    w_first_dur = '0;
    w_next_vld  = 1'b0;
    w_next_idx  = '0;
    w_next_dur  = '0;
    for (int k = N_INLETS - 1; k >= 0; k--) begin
      if (bus.i_dur[k*CNT_W +: CNT_W] != '0) begin
        w_first_vld = 1'b1;
        w_first_idx = 3'(k);
        w_first_dur = bus.i_dur[k*CNT_W +: CNT_W];
      end
      if ((k > int'(r_idx)) && (r_dur[k*CNT_W +: CNT_W] != '0)) begin
        w_next_vld = 1'b1;
        w_next_idx = 3'(k);
        w_next_dur = r_dur[k*CNT_W +: CNT_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_idx           <= '0;
      r_cnt           <= '0;
      r_dur           <= '0;
      bus.o_valve_en  <= '0;
      bus.o_flush_en  <= 1'b0;
      bus.o_busy      <= 1'b0;
      bus.o_done      <= 1'b0;
      bus.o_aborted   <= 1'b0;
      bus.o_cur_inlet <= '0;
    end else begin
      bus.o_done    <= 1'b0;
      bus.o_aborted <= 1'b0;
      if (bus.i_abort && (r_state == S_OPEN || r_state == S_SETTLE || r_state == S_FLUSH)) begin
        r_state         <= S_IDLE;
        r_idx           <= '0;
        r_cnt           <= '0;
        bus.o_valve_en  <= '0;
        bus.o_flush_en  <= 1'b0;
        bus.o_busy      <= 1'b0;
        bus.o_aborted   <= 1'b1;
        bus.o_cur_inlet <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.i_start && !bus.i_abort) begin
              r_dur      <= bus.i_dur;
              bus.o_busy <= 1'b1;
              if (w_first_vld) begin
                r_state         <= S_OPEN;
                r_idx           <= w_first_idx;
                r_cnt           <= w_first_dur - CNT_W'(1);
                bus.o_valve_en  <= N_INLETS'(1) << w_first_idx;
                bus.o_cur_inlet <= w_first_idx;
              end else begin
                r_state        <= S_FLUSH;
                r_cnt          <= CNT_W'(FLUSH_CYC - 1);
                bus.o_flush_en <= 1'b1;
              end
            end
          end
          S_OPEN: begin
            if (w_cnt_zero) begin
              r_state        <= S_SETTLE;
              r_cnt          <= CNT_W'(SETTLE_CYC - 1);
              bus.o_valve_en <= '0;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          S_SETTLE: begin
            if (!w_cnt_zero) begin
              r_cnt <= r_cnt - CNT_W'(1);
            end else if (w_next_vld) begin
              r_state         <= S_OPEN;
              r_idx           <= w_next_idx;
              r_cnt           <= w_next_dur - CNT_W'(1);
              bus.o_valve_en  <= N_INLETS'(1) << w_next_idx;
              bus.o_cur_inlet <= w_next_idx;
            end else begin
              r_state         <= S_FLUSH;
              r_idx           <= '0;
              r_cnt           <= CNT_W'(FLUSH_CYC - 1);
              bus.o_flush_en  <= 1'b1;
              bus.o_cur_inlet <= '0;
            end
          end
          S_FLUSH: begin
            if (w_cnt_zero) begin
              r_state        <= S_DONE;
              bus.o_flush_en <= 1'b0;
              bus.o_done     <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          S_DONE: begin
            r_state    <= S_IDLE;
            bus.o_busy <= 1'b0;
          end
          default: begin
            r_state         <= S_IDLE;
            r_idx           <= '0;
            r_cnt           <= '0;
            bus.o_valve_en  <= '0;
            bus.o_flush_en  <= 1'b0;
            bus.o_busy      <= 1'b0;
            bus.o_cur_inlet <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inlet_dispense_sequencer.sv
// Self-checking bench: per-cycle traces compared against a phase-list model of a run.
module tb_inlet_dispense_sequencer;
  localparam int N  = 3;
  localparam int CW = 16;
  localparam int ST = 2;
  localparam int FL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   inv_en   = 1'b0;
  logic [9:0] exp_q[$];

  inlet_dispense_sequencer_if #(.N_INLETS(N), .CNT_W(CW)) ifc ();

  inlet_dispense_sequencer #(.N_INLETS(N), .CNT_W(CW), .SETTLE_CYC(ST), .FLUSH_CYC(FL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] pk(logic [2:0] v, logic f, logic b, logic d, logic a, logic [2:0] c);
    return {v, f, b, d, a, c};
  endfunction

  function automatic logic [9:0] obs();
    return {ifc.o_valve_en, ifc.o_flush_en, ifc.o_busy, ifc.o_done, ifc.o_aborted, ifc.o_cur_inlet};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, o, e, $time);
  endtask

  // Expected trace: a list of phases (dose, settle per nonzero inlet; flush; done; idle).
  task automatic build_model(input int d[N]);
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      if (d[k] != 0) begin
        repeat (d[k]) exp_q.push_back(pk(3'(1 << k), 1'b0, 1'b1, 1'b0, 1'b0, 3'(k)));
        repeat (ST)   exp_q.push_back(pk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'(k)));
      end
    end
    repeat (FL) exp_q.push_back(pk(3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0));
    exp_q.push_back(pk(3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
    exp_q.push_back(pk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
  endtask

  task automatic run_trace(input int d0, input int d1, input int d2, input bit perturb,
                           output int busy_cnt, output int done_at, output int v0_cnt);
    int d[N];
    d[0] = d0; d[1] = d1; d[2] = d2;
    build_model(d);
    busy_cnt = 0; done_at = 0; v0_cnt = 0;
    ifc.i_dur   = {16'(d2), 16'(d1), 16'(d0)};
    ifc.i_start = 1'b1;
    for (int j = 0; j < exp_q.size(); j++) begin
      @(posedge clk); #1;
      if (j == 0) ifc.i_start = 1'b0;
      check("trace", 32'(obs()), 32'(exp_q[j]));
      if (ifc.o_busy) busy_cnt++;
      if (ifc.o_done) done_at = j + 1;
      if (ifc.o_valve_en[0]) v0_cnt++;
      if (perturb && j < exp_q.size() - 2) begin
        ifc.i_start = 1'($urandom_range(0, 1));
        ifc.i_dur   = {16'($urandom), 16'($urandom), 16'($urandom)};
      end
    end
    ifc.i_start = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      check(tag, 32'(obs()), 32'(pk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0)));
    end
  endtask

  task automatic wait_valve(input int k, output bit ok);
    ok = 1'b0;
    for (int j = 0; j < 200 && !ok; j++) begin
      @(posedge clk); #1;
      if (ifc.o_valve_en[k]) ok = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (inv_en && !rst) begin
      check("onehot", 32'($onehot0(ifc.o_valve_en)), 32'd1);
      check("exclusive", 32'((|ifc.o_valve_en) && ifc.o_flush_en), 32'd0);
    end
  end

  initial begin
    int bc, da, v0;
    bit ok;
    ifc.i_start = 1'b0;
    ifc.i_abort = 1'b0;
    ifc.i_dur   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(obs()), 32'd0);
    rst    = 1'b0;
    inv_en = 1'b1;

    run_trace(3, 0, 5, 1'b0, bc, da, v0);
    check("s2_busy_cycles", 32'(bc), 32'd17);
    check("s2_done_cycle", 32'(da), 32'd17);

    run_trace(0, 0, 0, 1'b0, bc, da, v0);
    check("s3_busy_cycles", 32'(bc), 32'd5);
    check("s3_done_cycle", 32'(da), 32'd5);

    run_trace(3, 0, 5, 1'b1, bc, da, v0);
    check("s5_done_cycle", 32'(da), 32'd17);

    for (int r = 0; r < 10; r++) begin
      idle_cycles($urandom_range(0, 2), "gap_idle");
      run_trace($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                1'($urandom_range(0, 1)), bc, da, v0);
    end

    // Reset mid-dose, between clock edges.
    ifc.i_dur   = {16'd0, 16'd0, 16'd6};
    ifc.i_start = 1'b1;
    @(posedge clk); #1;
    ifc.i_start = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_reset", 32'(obs()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(3, "post_reset_idle");
    run_trace(2, 4, 1, 1'b0, bc, da, v0);

    // Abort during inlet 2 dose.
    ifc.i_dur   = {16'($urandom_range(4, 8)), 16'd0, 16'($urandom_range(0, 3))};
    ifc.i_start = 1'b1;
    @(posedge clk); #1;
    ifc.i_start = 1'b0;
    wait_valve(2, ok);
    check("wait_inlet2", 32'(ok), 32'd1);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
    ifc.i_abort = 1'b1;
    @(posedge clk); #1;
    ifc.i_abort = 1'b0;
    check("abort_pulse", 32'(obs()), 32'(pk(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0)));
    idle_cycles(6, "post_abort_idle");

    // Abort during flush.
    ifc.i_dur   = '0;
    ifc.i_start = 1'b1;
    @(posedge clk); #1;
    ifc.i_start = 1'b0;
    @(posedge clk); #1;
    ifc.i_abort = 1'b1;
    @(posedge clk); #1;
    ifc.i_abort = 1'b0;
    check("abort_flush", 32'(obs()), 32'(pk(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0)));
    idle_cycles(6, "post_abort_flush_idle");

    // Start together with abort in IDLE is dropped.
    ifc.i_dur   = {16'd1, 16'd1, 16'd1};
    ifc.i_start = 1'b1;
    ifc.i_abort = 1'b1;
    @(posedge clk); #1;
    ifc.i_start = 1'b0;
    ifc.i_abort = 1'b0;
    idle_cycles(4, "start_abort_idle");

    run_trace(65535, 1, 0, 1'b0, bc, da, v0);
    check("max_dose_cycles", 32'(v0), 32'd65535);

    inv_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
